writeback_regfile: RTL

Writeback-stage sink and architectural register file for the 5-stage RV32I pipeline. It consumes the registered W-stage bundle produced by the MEM→WB pipeline register, selects the write-back result, commits it to a 32×32 register file, and serves the decode stage's two asynchronous read ports. Same-cycle write/read bypass lets decode see a value in the cycle it is written. It exports ResultW for EX-stage forwarding, a0 for test observation, and a retired-write counter.

---
 rtl/writeback_regfile.sv | 86 ++++++++
 1 files changed

// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module      : writeback_regfile
// Description : RV32I writeback stage and 32x32 register file. Provides two
//               bypassed decode read ports and a retired-write counter.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_regfile #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ALUResultW,
    input  logic [WIDTH-1:0] ReadDataW,
    input  logic [WIDTH-1:0] PCPlus4W,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcW,
    input  logic [4:0]       A1D,
    input  logic [4:0]       A2D,
    output logic [WIDTH-1:0] RD1D,
    output logic [WIDTH-1:0] RD2D,
    output logic [WIDTH-1:0] ResultW,
    output logic [WIDTH-1:0] a0,
    output logic [31:0]      WritesRetired
);

    localparam logic [1:0] c_SRC_ALU  = 2'b00;
    localparam logic [1:0] c_SRC_MEM  = 2'b01;
    localparam logic [1:0] c_SRC_LINK = 2'b10;

    logic [WIDTH-1:0] r_regs [32];
    logic [31:0]      r_writes_retired;
    logic [WIDTH-1:0] w_result;
    logic             w_commit;

    // The reserved encoding 2'b11 falls through to the ALU result.
    always_comb begin
        w_result = ALUResultW;
        case (ResultSrcW)
            c_SRC_ALU:  w_result = ALUResultW;
            c_SRC_MEM:  w_result = ReadDataW;
            c_SRC_LINK: w_result = PCPlus4W;
            default:    w_result = ALUResultW;
        endcase
    end

    assign w_commit = RegWriteW && (RdW != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
            r_writes_retired <= '0;
        end else if (w_commit) begin
            r_regs[RdW]      <= w_result;
            r_writes_retired <= r_writes_retired + 32'd1;
        end
    end

    // Same-cycle bypass lets decode see the value being committed this cycle.
    always_comb begin
        RD1D = r_regs[A1D];
        if (A1D == 5'd0) begin
            RD1D = '0;
        end else if (w_commit && (RdW == A1D)) begin
            RD1D = w_result;
        end
    end

    always_comb begin
        RD2D = r_regs[A2D];
        if (A2D == 5'd0) begin
            RD2D = '0;
        end else if (w_commit && (RdW == A2D)) begin
            RD2D = w_result;
        end
    end

    assign ResultW       = w_result;
    assign a0            = r_regs[10];
    assign WritesRetired = r_writes_retired;

endmodule
`default_nettype wire
